// File: rtl/branch_resolve_pkg.sv
// branch_resolve_pkg: funct3 encodings, FSM states and link increment shared by branch_resolve files.
package branch_resolve_pkg;
   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;
   typedef enum logic [1:0] {IDLE = 2'd0, REDIRECT = 2'd1, FLUSH = 2'd2} state_e;
   localparam logic [31:0] PC_STEP = 32'h4;
endpackage

// File: rtl/branch_resolve_if.sv
// branch_resolve_if: execute-side inputs and fetch/pipeline-side outputs of branch_resolve.
interface branch_resolve_if;
   logic        i_valid;
   logic        i_is_jal;
   logic        i_is_jalr;
   logic [2:0]  i_funct3;
   logic [31:0] i_pc;
   logic [31:0] i_rs1;
   logic [31:0] i_rs2;
   logic [31:0] i_imm;
   logic        i_fetch_ready;
   logic        b_taken_out;
   logic [31:0] b_pc_out;
   logic        flush_out;
   logic        busy_out;
   logic [31:0] link_out;
   logic        misalign_out;
   modport master (
      output i_valid, i_is_jal, i_is_jalr, i_funct3, i_pc, i_rs1, i_rs2, i_imm, i_fetch_ready,
      input  b_taken_out, b_pc_out, flush_out, busy_out, link_out, misalign_out
   );
   modport slave (
      input  i_valid, i_is_jal, i_is_jalr, i_funct3, i_pc, i_rs1, i_rs2, i_imm, i_fetch_ready,
      output b_taken_out, b_pc_out, flush_out, busy_out, link_out, misalign_out
   );
endinterface

// File: rtl/branch_cmp.sv
// branch_cmp: conditional-branch decision from funct3 and the two operands.
module branch_cmp
   import branch_resolve_pkg::*;
(
   input  logic [2:0]  funct3_i,
   input  logic [31:0] rs1_i,
   input  logic [31:0] rs2_i,
   output logic        taken_o
);
   logic eq, lt, ltu;
   always_comb begin
      eq  = rs1_i == rs2_i;
      lt  = $signed(rs1_i) < $signed(rs2_i);
      ltu = rs1_i < rs2_i;
      taken_o = (funct3_i == F3_BEQ)  ? eq   :
                (funct3_i == F3_BNE)  ? !eq  :
                (funct3_i == F3_BLT)  ? lt   :
                (funct3_i == F3_BGE)  ? !lt  :
                (funct3_i == F3_BLTU) ? ltu  :
                (funct3_i == F3_BGEU) ? !ltu : 1'b0;
   end
endmodule

// File: rtl/branch_resolve.sv
// branch_resolve: execute-stage branch/jump resolution, redirect handshake and flush sequencing.
// Optional misaligned-target trap enabled by defining BRANCH_MISALIGN_TRAP_EN.
module branch_resolve
   import branch_resolve_pkg::*;
#(
   parameter int FLUSH_CYCLES = 2
) (
   input logic             i_clk,
   input logic             i_rst_n,
   branch_resolve_if.slave bus
);
   logic        cmp_taken, is_jump, taken, mis, accept;
   logic [31:0] raw, target;
   state_e      state_q;
   logic [3:0]  cnt_q;
   logic        taken_q, flush_q;
   logic [31:0] pc_q, link_q;

   branch_cmp u_cmp (
      .funct3_i (bus.i_funct3),
      .rs1_i    (bus.i_rs1),
      .rs2_i    (bus.i_rs2),
      .taken_o  (cmp_taken)
   );

   always_comb begin
      is_jump = bus.i_is_jal | bus.i_is_jalr;
      taken   = is_jump | cmp_taken;
      raw     = bus.i_is_jalr ? ((bus.i_rs1 + bus.i_imm) & ~32'h1) : (bus.i_pc + bus.i_imm);
`ifdef BRANCH_MISALIGN_TRAP_EN
      mis     = |raw[1:0];
      target  = raw;
`else
      mis     = 1'b0;
      target  = raw & ~32'h3;
`endif
      accept  = bus.i_valid & taken & ~mis;
   end

`ifdef BRANCH_MISALIGN_TRAP_EN
   logic mis_q;
   // Pulse lands where b_taken_out would have risen for an aligned target
   always_ff @(posedge i_clk)
      if (!i_rst_n) mis_q <= 1'b0;
      else mis_q <= (state_q == IDLE) & bus.i_valid & taken & mis;
   assign bus.misalign_out = mis_q;
`else
   assign bus.misalign_out = 1'b0;
`endif

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         taken_q <= 1'b0;
         flush_q <= 1'b0;
         pc_q    <= 32'h0;
         link_q  <= 32'h0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.i_valid & is_jump) link_q <= bus.i_pc + PC_STEP;
               if (accept) begin
                  state_q <= REDIRECT;
                  taken_q <= 1'b1;
                  flush_q <= 1'b1;
                  pc_q    <= target;
               end
            end
            REDIRECT: begin
               if (bus.i_fetch_ready) begin
                  state_q <= FLUSH;
                  taken_q <= 1'b0;
                  cnt_q   <= 4'(FLUSH_CYCLES - 1);
               end
            end
            FLUSH: begin
               if (cnt_q == 4'd0) begin
                  state_q <= IDLE;
                  flush_q <= 1'b0;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.b_taken_out = taken_q;
   assign bus.b_pc_out    = pc_q;
   assign bus.flush_out   = flush_q;
   assign bus.busy_out    = state_q != IDLE;
   assign bus.link_out    = link_q;
endmodule

// File: tb/tb_branch_resolve.sv
// tb_branch_resolve: vector table, hand sequences and random instructions against a spec-level model.
module tb_branch_resolve;
   localparam int FC = 2;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int n_chk = 0;
   int n_fail = 0;
   logic [31:0] exp_pc = 32'h0;
   logic [31:0] exp_link = 32'h0;

   always #5 clk = ~clk;

   branch_resolve_if bus();
   branch_resolve #(.FLUSH_CYCLES(FC)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

   typedef struct {
      string       name;
      logic        jal;
      logic        jalr;
      logic [2:0]  f3;
      logic [31:0] pc;
      logic [31:0] rs1;
      logic [31:0] rs2;
      logic [31:0] imm;
      logic        taken;
      logic [31:0] raw;
      int          hold;
   } vec_t;

   function automatic vec_t mk(input string name, input logic jal, input logic jalr, input logic [2:0] f3,
                               input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] rs2,
                               input logic [31:0] imm, input logic taken, input logic [31:0] raw, input int hold);
      vec_t v;
      v.name = name; v.jal = jal; v.jalr = jalr; v.f3 = f3; v.pc = pc; v.rs1 = rs1; v.rs2 = rs2;
      v.imm = imm; v.taken = taken; v.raw = raw; v.hold = hold;
      return v;
   endfunction

   function automatic logic ref_taken(input vec_t v);
      if (v.jal || v.jalr) return 1'b1;
      case (v.f3)
         3'd0: return v.rs1 == v.rs2;
         3'd1: return v.rs1 != v.rs2;
         3'd4: return int'(v.rs1) < int'(v.rs2);
         3'd5: return int'(v.rs1) >= int'(v.rs2);
         3'd6: return v.rs1 < v.rs2;
         3'd7: return v.rs1 >= v.rs2;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] ref_raw(input vec_t v);
      return v.jalr ? ((v.rs1 + v.imm) & ~32'h1) : (v.pc + v.imm);
   endfunction

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      bus.i_valid = 1'b1; bus.i_is_jal = v.jal; bus.i_is_jalr = v.jalr; bus.i_funct3 = v.f3;
      bus.i_pc = v.pc; bus.i_rs1 = v.rs1; bus.i_rs2 = v.rs2; bus.i_imm = v.imm;
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 40 && bus.busy_out; i++) step;
      chk({name, "_drain_busy"}, 32'(bus.busy_out), 32'd0);
      chk({name, "_drain_flush"}, 32'(bus.flush_out), 32'd0);
   endtask

   task automatic issue(input vec_t v);
      logic mis;
      logic go;
      logic [31:0] tgt;
      int n;
      mis = 1'b0;
      tgt = v.raw & ~32'h3;
`ifdef BRANCH_MISALIGN_TRAP_EN
      mis = v.taken && (v.raw[1:0] != 2'b00);
      tgt = v.raw;
`endif
      go = v.taken && !mis;
      drive(v);
      bus.i_fetch_ready = 1'b0;
      step;
      bus.i_valid = 1'b0;
      if (v.jal || v.jalr) exp_link = v.pc + 32'h4;
      if (go) exp_pc = tgt;
      chk({v.name, "_taken"}, 32'(bus.b_taken_out), 32'(go));
      chk({v.name, "_pc"}, bus.b_pc_out, exp_pc);
      chk({v.name, "_link"}, bus.link_out, exp_link);
      chk({v.name, "_misalign"}, 32'(bus.misalign_out), 32'(mis));
      chk({v.name, "_flush"}, 32'(bus.flush_out), 32'(go));
      n = bus.flush_out ? 1 : 0;
      for (int i = 0; i < v.hold; i++) begin
         step;
         if (bus.flush_out) n++;
         chk({v.name, "_hold_taken"}, 32'(bus.b_taken_out), 32'(go));
         chk({v.name, "_hold_pc"}, bus.b_pc_out, exp_pc);
      end
      bus.i_fetch_ready = 1'b1;
      step;
      bus.i_fetch_ready = 1'b0;
      if (bus.flush_out) n++;
      chk({v.name, "_taken_after_ready"}, 32'(bus.b_taken_out), 32'd0);
      chk({v.name, "_misalign_end"}, 32'(bus.misalign_out), 32'd0);
      for (int i = 0; i < 40 && bus.busy_out; i++) begin
         step;
         if (bus.flush_out) n++;
      end
      chk({v.name, "_flush_len"}, 32'(n), go ? 32'(1 + v.hold + FC) : 32'd0);
      chk({v.name, "_idle"}, 32'(bus.busy_out), 32'd0);
      chk({v.name, "_pc_kept"}, bus.b_pc_out, exp_pc);
   endtask

   vec_t tbl[12];

   initial begin
      vec_t v;
      tbl[0]  = mk("beq_eq",   0, 0, 3'b000, 32'h100, 32'd5, 32'd5, 32'h20, 1, 32'h120, 0);
      tbl[1]  = mk("blt_neg",  0, 0, 3'b100, 32'h200, 32'hffffffff, 32'd1, 32'h10, 1, 32'h210, 0);
      tbl[2]  = mk("bltu_neg", 0, 0, 3'b110, 32'h200, 32'hffffffff, 32'd1, 32'h10, 0, 32'h210, 0);
      tbl[3]  = mk("bne_eq",   0, 0, 3'b001, 32'h300, 32'd7, 32'd7, 32'h40, 0, 32'h340, 0);
      tbl[4]  = mk("bge_neg",  0, 0, 3'b101, 32'h300, 32'hffffffff, 32'd1, 32'h40, 0, 32'h340, 1);
      tbl[5]  = mk("bgeu_neg", 0, 0, 3'b111, 32'h300, 32'hffffffff, 32'd1, 32'hfffffff8, 1, 32'h2f8, 1);
      tbl[6]  = mk("f3_010",   0, 0, 3'b010, 32'h400, 32'd1, 32'd1, 32'h8, 0, 32'h408, 0);
      tbl[7]  = mk("jalr",     0, 1, 3'b000, 32'h40, 32'h203, 32'd0, 32'h4, 1, 32'h206, 3);
      tbl[8]  = mk("jal_odd",  1, 0, 3'b000, 32'h100, 32'd0, 32'd0, 32'h6, 1, 32'h106, 0);
      tbl[9]  = mk("both_jmp", 1, 1, 3'b001, 32'h1000, 32'h80, 32'h80, 32'h10, 1, 32'h90, 1);
      tbl[10] = mk("wrap",     0, 0, 3'b000, 32'hfffffff0, 32'd9, 32'd9, 32'h20, 1, 32'h10, 0);
      tbl[11] = mk("jalr_b0",  0, 1, 3'b111, 32'h80, 32'h101, 32'd0, 32'h0, 1, 32'h100, 2);

      bus.i_valid = 0; bus.i_is_jal = 0; bus.i_is_jalr = 0; bus.i_funct3 = 0; bus.i_pc = 0;
      bus.i_rs1 = 0; bus.i_rs2 = 0; bus.i_imm = 0; bus.i_fetch_ready = 0;
      step;
      step;
      chk("rst_taken", 32'(bus.b_taken_out), 32'd0);
      chk("rst_pc", bus.b_pc_out, 32'h0);
      chk("rst_flush", 32'(bus.flush_out), 32'd0);
      chk("rst_busy", 32'(bus.busy_out), 32'd0);
      chk("rst_link", bus.link_out, 32'h0);
      chk("rst_misalign", 32'(bus.misalign_out), 32'd0);
      rst_n = 1'b1;
      step;

      for (int i = 0; i < 12; i++) issue(tbl[i]);

      // Younger taken branch during FLUSH is dropped; one arriving on the first IDLE cycle is taken
      drive(mk("a", 0, 0, 3'b000, 32'h500, 32'd3, 32'd3, 32'h40, 1, 32'h540, 0));
      step;
      chk("ff_first_pc", bus.b_pc_out, 32'h540);
      drive(mk("b", 0, 0, 3'b001, 32'h600, 32'd1, 32'd2, 32'h80, 1, 32'h680, 0));
      bus.i_fetch_ready = 1'b1;
      step;
      bus.i_fetch_ready = 1'b0;
      for (int i = 0; i < 40 && bus.busy_out; i++) begin
         chk("ff_ignored_pc", bus.b_pc_out, 32'h540);
         chk("ff_ignored_taken", 32'(bus.b_taken_out), 32'd0);
         step;
      end
      chk("ff_back_idle", 32'(bus.busy_out), 32'd0);
      step;
      bus.i_valid = 1'b0;
      chk("ff_fresh_taken", 32'(bus.b_taken_out), 32'd1);
      chk("ff_fresh_pc", bus.b_pc_out, 32'h680);
      exp_pc = 32'h680;
      bus.i_fetch_ready = 1'b1;
      step;
      bus.i_fetch_ready = 1'b0;
      drain("ff");

      // Reset while a redirect is pending
      drive(mk("r", 1, 0, 3'b000, 32'h700, 32'd0, 32'd0, 32'h100, 1, 32'h800, 0));
      step;
      bus.i_valid = 1'b0;
      chk("rr_taken_pre", 32'(bus.b_taken_out), 32'd1);
      rst_n = 1'b0;
      step;
      chk("rr_taken", 32'(bus.b_taken_out), 32'd0);
      chk("rr_pc", bus.b_pc_out, 32'h0);
      chk("rr_flush", 32'(bus.flush_out), 32'd0);
      chk("rr_busy", 32'(bus.busy_out), 32'd0);
      chk("rr_link", bus.link_out, 32'h0);
      rst_n = 1'b1;
      step;
      chk("rr_no_flush", 32'(bus.flush_out), 32'd0);
      exp_pc = 32'h0;
      exp_link = 32'h0;

      for (int i = 0; i < 40; i++) begin
         v.name = "rnd";
         v.jal = $urandom_range(0, 3) == 0;
         v.jalr = $urandom_range(0, 3) == 0;
         v.f3 = 3'($urandom);
         v.pc = $urandom & ~32'h3;
         v.rs1 = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 4);
         v.rs2 = $urandom_range(0, 2) == 0 ? v.rs1 : ($urandom_range(0, 1) ? $urandom : $urandom_range(0, 4));
         v.imm = $urandom_range(0, 1) ? (($urandom & 32'hfff) - 32'h800) : $urandom;
         v.taken = ref_taken(v);
         v.raw = ref_raw(v);
         v.hold = $urandom_range(0, 3);
         issue(v);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
